// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V core and its instruction-memory loader.
package riscv_pkg;

  localparam int DW             = 32;
  localparam int MEM_SIZE_IN_KB = 1;
  localparam int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    RELEASE
  } loader_state_e;

endpackage

// File: rtl/riscv_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; first byte lands in bits [7:0].
module riscv_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_next_o,
  output logic        word_done_o
);

  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;

  // word_next_o already contains the byte being accepted, so the final word can be captured on the same edge
  always_comb begin
    word_next_o = word_q;
    word_next_o[{byte_cnt_q, 3'b000} +: 8] = byte_i;
  end

  assign word_done_o = accept_i && (byte_cnt_q == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
    end else if (clear_i) begin
      byte_cnt_q <= 2'd0;
    end else if (accept_i) begin
      word_q     <= word_next_o;
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/riscv_imem_loader.sv
// Loads a byte stream into instruction memory from word 0 and holds the core in reset until the load finishes.
module riscv_imem_loader #(
  parameter int DW             = riscv_pkg::DW,
  parameter int MEM_SIZE_IN_KB = riscv_pkg::MEM_SIZE_IN_KB,
  parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
  parameter int ADDRW          = $clog2(NO_OF_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [ADDRW:0]   len_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  output logic             core_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  import riscv_pkg::*;

  localparam logic [ADDRW:0] MAX_LEN = (ADDRW + 1)'(NO_OF_REGS);
  localparam logic [ADDRW:0] ONE     = (ADDRW + 1)'(1);

  loader_state_e    state_q, state_d;
  logic [ADDRW-1:0] addr_q;
  logic [ADDRW:0]   words_left_q;
  logic             len_ok, accept, word_done, load_start;
  logic [31:0]      word_next;

  assign len_ok       = (len_i != '0) && (len_i <= MAX_LEN);
  assign byte_ready_o = (state_q == COLLECT);
  assign busy_o       = (state_q != IDLE);
  assign accept       = byte_valid_i && byte_ready_o;
  assign load_start   = (state_q == IDLE) && start_i && len_ok;

  riscv_byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (load_start),
    .accept_i    (accept),
    .byte_i      (byte_i),
    .word_next_o (word_next),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = COLLECT;
      COLLECT: if (word_done)  state_d = WRITE;
      WRITE:   state_d = (words_left_q == ONE) ? RELEASE : COLLECT;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe, address and data are registered on the last-byte edge so all three are valid during WRITE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      words_left_q <= '0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      core_rst_o   <= 1'b1;
    end else begin
      mem_we_o <= word_done;
      done_o   <= (state_q == RELEASE);
      err_o    <= (state_q == IDLE) && start_i && !len_ok;
      if (word_done) begin
        mem_addr_o  <= addr_q;
        mem_wdata_o <= word_next;
      end
      case (state_q)
        IDLE: begin
          if (load_start) begin
            words_left_q <= len_i;
            addr_q       <= '0;
            core_rst_o   <= 1'b1;
          end else if (!start_i) begin
            core_rst_o   <= 1'b0;
          end
        end
        WRITE: begin
          words_left_q <= words_left_q - ONE;
          // The final address is never advanced, so a full-memory load cannot wrap
          if (words_left_q != ONE) addr_q <= addr_q + 1'b1;
        end
        RELEASE: core_rst_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
